sync_fifo_flags: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed RX/TX buffers between the UART and the interface/ALU controller. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. A selectable read mode chooses between first-word fall-through and a registered read with a valid strobe.

---
 rtl/sync_fifo_flags.sv | 136 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with count, almost/error flags and selectable read mode
module sync_fifo_flags #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = (1 << ADDR_W) - 2,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              rd,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int             DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              ae_q, ae_d;
   logic              af_q, af_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wr_acc, rd_acc;

   // Acceptance uses only registered flags, so wr/rd never reach the flags combinationally.
   assign wr_acc = wr && !full_q;
   assign rd_acc = rd && !empty_q;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (clr) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
         if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
         if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
         else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
         if (wr && full_q)  ovf_d = 1'b1;
         if (rd && empty_q) udf_d = 1'b1;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
      ae_d    = (count_d <= AE_C);
      af_d    = (count_d >= AF_C);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= (AF_C == '0);
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ae_q    <= ae_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !clr) mem_q[w_ptr_q] <= w_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign r_data  = mem_q[r_ptr_q];
         assign r_valid = !empty_q;
      end else begin : g_reg
         logic [DATA_W-1:0] r_data_q;
         logic              r_valid_q;

         // r_data keeps the last popped word through a flush; only the strobe is cleared.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_data_q  <= '0;
               r_valid_q <= 1'b0;
            end else if (clr) begin
               r_valid_q <= 1'b0;
            end else begin
               r_valid_q <= rd_acc;
               if (rd_acc) r_data_q <= mem_q[r_ptr_q];
            end
         end

         assign r_data  = r_data_q;
         assign r_valid = r_valid_q;
      end
   endgenerate

   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr, wr, rd;
   logic [7:0] w_data;
   logic [7:0] r_data;
   logic       r_valid, empty, full, almost_empty, almost_full, overflow, underflow;
   logic [2:0] count;

   logic       clr2, wr2, rd2;
   logic [7:0] w_data2;
   logic [7:0] r_data2;
   logic       r_valid2, empty2, full2, almost_empty2, almost_full2, overflow2, underflow2;
   logic [2:0] count2;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] sb[$];
   logic       movf = 1'b0;
   logic       mudf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_dut (
      .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
      .r_data(r_data), .r_valid(r_valid), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flags #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_dut_reg (
      .clk(clk), .reset(reset), .clr(clr2), .wr(wr2), .w_data(w_data2), .rd(rd2),
      .r_data(r_data2), .r_valid(r_valid2), .empty(empty2), .full(full2),
      .almost_empty(almost_empty2), .almost_full(almost_full2), .count(count2),
      .overflow(overflow2), .underflow(underflow2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = sb.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == 4));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 3));
      chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(mudf));
      chk({tag, ".r_valid"}, 32'(r_valid), 32'(n != 0));
      if (n != 0) chk({tag, ".r_data"}, 32'(r_data), 32'(sb[0]));
   endtask

   // Entered on a falling edge; drives one cycle and updates the scoreboard model.
   task automatic cyc(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic c);
      logic mf, me;
      mf = (sb.size() == 4);
      me = (sb.size() == 0);
      wr = w; w_data = d; rd = r; clr = c;
      if (c) begin
         sb.delete();
         movf = 1'b0;
         mudf = 1'b0;
      end else begin
         if (w && mf) movf = 1'b1;
         if (r && me) mudf = 1'b1;
         if (r && !me) void'(sb.pop_front());
         if (w && !mf) sb.push_back(d);
      end
      @(negedge clk);
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
      check_state(tag);
   endtask

   initial begin
      reset = 1'b1;
      clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
      clr2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0; w_data2 = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check_state("reset");
      chk("reset.reg_r_valid", 32'(r_valid2), 32'd0);
      chk("reset.reg_r_data", 32'(r_data2), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Fill then drain
      cyc("fill", 1'b1, 8'h11, 1'b0, 1'b0);
      cyc("fill", 1'b1, 8'h22, 1'b0, 1'b0);
      cyc("fill", 1'b1, 8'h33, 1'b0, 1'b0);
      cyc("fill", 1'b1, 8'h44, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Overflow: write while full is dropped
      cyc("ovf_fill", 1'b1, 8'h11, 1'b0, 1'b0);
      cyc("ovf_fill", 1'b1, 8'h22, 1'b0, 1'b0);
      cyc("ovf_fill", 1'b1, 8'h33, 1'b0, 1'b0);
      cyc("ovf_fill", 1'b1, 8'h44, 1'b0, 1'b0);
      cyc("ovf_wr", 1'b1, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow with simultaneous rd/wr on empty, then rd/wr at count 2
      cyc("udf_rw", 1'b1, 8'hA5, 1'b1, 1'b0);
      chk("udf.r_data_a5", 32'(r_data), 32'h0A5);
      cyc("rw_fill", 1'b1, 8'hB6, 1'b0, 1'b0);
      cyc("rw_both", 1'b1, 8'hC7, 1'b1, 1'b0);
      cyc("rw_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      cyc("rw_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Wrap-around after clearing sticky flags
      cyc("clr0", 1'b0, 8'h00, 1'b0, 1'b1);
      cyc("wrap_wr", 1'b1, 8'd0, 1'b0, 1'b0);
      cyc("wrap_wr", 1'b1, 8'd1, 1'b0, 1'b0);
      for (int i = 2; i < 10; i++) cyc("wrap_rw", 1'b1, 8'(i), 1'b1, 1'b0);
      cyc("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      cyc("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Flush with overflow set and a concurrent write
      for (int i = 0; i < 4; i++) cyc("fl_fill", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      cyc("fl_ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
      cyc("fl_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      cyc("fl_clr", 1'b1, 8'h77, 1'b0, 1'b1);
      cyc("fl_rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);

      // Registered read mode
      wr2 = 1'b1; w_data2 = 8'h3C;
      @(negedge clk);
      wr2 = 1'b0; rd2 = 1'b1;
      chk("reg.pre_rd_valid", 32'(r_valid2), 32'd0);
      @(negedge clk);
      rd2 = 1'b0;
      chk("reg.n1_valid", 32'(r_valid2), 32'd1);
      chk("reg.n1_data", 32'(r_data2), 32'h3C);
      chk("reg.n1_count", 32'(count2), 32'd0);
      @(negedge clk);
      chk("reg.n2_valid", 32'(r_valid2), 32'd0);
      chk("reg.n2_hold", 32'(r_data2), 32'h3C);
      rd2 = 1'b1;
      @(negedge clk);
      rd2 = 1'b0;
      chk("reg.rej_valid", 32'(r_valid2), 32'd0);
      chk("reg.rej_udf", 32'(underflow2), 32'd1);
      chk("reg.rej_hold", 32'(r_data2), 32'h3C);
      wr2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_data2 = 8'(8'hA1 + i);
         @(negedge clk);
      end
      wr2 = 1'b0; rd2 = 1'b1;
      @(negedge clk);
      chk("reg.burst_valid", 32'(r_valid2), 32'd1);
      chk("reg.burst_data", 32'(r_data2), 32'hA1);
      chk("reg.burst_count", 32'(count2), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("arst.count", 32'(count2), 32'd0);
      chk("arst.r_data", 32'(r_data2), 32'd0);
      chk("arst.r_valid", 32'(r_valid2), 32'd0);
      chk("arst.empty", 32'(empty2), 32'd1);
      chk("arst.underflow", 32'(underflow2), 32'd0);
      #1 reset = 1'b0;
      rd2 = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
